// File: rtl/pipe_controller.sv
// RV32 decode + D->E control register; imm_src_d is combinational, E controls land one edge later.
// DIV/REM (define MULDIV_EN) hold E for DIV_LATENCY cycles and raise md_stall to freeze F/D.
module pipe_controller #(
    parameter int ALUCTRL_W   = 5,
    parameter int IMMSRC_W    = 3,
    parameter int DIV_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_d,
    input  logic                 flush_e,
    output logic [IMMSRC_W-1:0]  imm_src_d,
    output logic                 reg_write_e,
    output logic                 mem_write_e,
    output logic                 alu_src_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic                 auipc_e,
    output logic [1:0]           result_src_e,
    output logic [ALUCTRL_W-1:0] alu_control_e,
    output logic                 valid_e,
    output logic                 illegal_e,
    output logic                 md_stall
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_SLL   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_SRA   = 5'b00110;
    localparam logic [4:0] ALU_OR    = 5'b01000;
    localparam logic [4:0] ALU_AND   = 5'b01001;
    localparam logic [4:0] ALU_XOR   = 5'b01010;
    localparam logic [4:0] ALU_SLT   = 5'b01011;
    localparam logic [4:0] ALU_SLTU  = 5'b01100;
    localparam logic [4:0] ALU_PASSB = 5'b10000;
`ifdef MULDIV_EN
    localparam logic [4:0] ALU_MUL   = 5'b00010;
    localparam logic [4:0] ALU_DIV   = 5'b00011;
    localparam logic [4:0] ALU_REM   = 5'b00111;
`endif

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc;
        logic [1:0] result_src;
        logic [4:0] alu;
    } ctrl_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [14:0] unused_fields;
    ctrl_t       dec;
    logic [2:0]  imm_d;
    logic        illegal_d;
`ifdef MULDIV_EN
    logic        md_d;
`endif

    assign opcode        = instr_d[6:0];
    assign funct3        = instr_d[14:12];
    assign funct7        = instr_d[31:25];
    assign unused_fields = {instr_d[24:15], instr_d[11:7]};

    always_comb begin
        dec       = '0;
        imm_d     = IMM_I;
        illegal_d = 1'b0;
`ifdef MULDIV_EN
        md_d      = 1'b0;
`endif
        case (opcode)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                illegal_d      = (funct3 != 3'b010);
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_d         = IMM_S;
                illegal_d     = (funct3 != 3'b010);
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec.alu = ALU_ADD;
                            3'b001:  dec.alu = ALU_SLL;
                            3'b010:  dec.alu = ALU_SLT;
                            3'b011:  dec.alu = ALU_SLTU;
                            3'b100:  dec.alu = ALU_XOR;
                            3'b101:  dec.alu = ALU_SRL;
                            3'b110:  dec.alu = ALU_OR;
                            default: dec.alu = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  dec.alu = ALU_SUB;
                            3'b101:  dec.alu = ALU_SRA;
                            default: illegal_d = 1'b1;
                        endcase
                    end
`ifdef MULDIV_EN
                    7'b0000001: begin
                        // signed/unsigned variants share a code; the divider reads funct3 itself
                        case (funct3)
                            3'b000:          dec.alu = ALU_MUL;
                            3'b100, 3'b101: begin dec.alu = ALU_DIV; md_d = 1'b1; end
                            3'b110, 3'b111: begin dec.alu = ALU_REM; md_d = 1'b1; end
                            default:         illegal_d = 1'b1;
                        endcase
                    end
`endif
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_BR: begin
                dec.branch = 1'b1;
                imm_d      = IMM_B;
                case (funct3)
                    3'b000, 3'b001: dec.alu = ALU_SUB;
                    3'b100, 3'b101: dec.alu = ALU_SLT;
                    3'b110, 3'b111: dec.alu = ALU_SLTU;
                    default:        illegal_d = 1'b1;
                endcase
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                case (funct3)
                    3'b000:  dec.alu = ALU_ADD;
                    3'b001:  dec.alu = ALU_SLL;
                    3'b010:  dec.alu = ALU_SLT;
                    3'b011:  dec.alu = ALU_SLTU;
                    3'b100:  dec.alu = ALU_XOR;
                    3'b101:  dec.alu = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu = ALU_OR;
                    default: dec.alu = ALU_AND;
                endcase
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_d          = IMM_J;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.jalr       = 1'b1;
                dec.result_src = 2'b10;
                illegal_d      = (funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu       = ALU_PASSB;
                imm_d         = IMM_U;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.auipc     = 1'b1;
                imm_d         = IMM_U;
            end
            default: illegal_d = 1'b1;
        endcase
        // an undecodable instruction must not write anything or redirect the PC
        if (illegal_d) begin
            dec   = '0;
            imm_d = IMM_I;
`ifdef MULDIV_EN
            md_d  = 1'b0;
`endif
        end
    end

    assign imm_src_d = IMMSRC_W'(imm_d);

    ctrl_t ctrl_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e    <= '0;
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
        end else if (flush_e || (stall_d && !md_stall)) begin
            ctrl_e    <= '0;
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
        end else if (!md_stall) begin
            ctrl_e    <= valid_d ? dec : '0;
            valid_e   <= valid_d;
            illegal_e <= valid_d & illegal_d;
        end
    end

    assign reg_write_e   = ctrl_e.reg_write;
    assign mem_write_e   = ctrl_e.mem_write;
    assign alu_src_e     = ctrl_e.alu_src;
    assign branch_e      = ctrl_e.branch;
    assign jump_e        = ctrl_e.jump;
    assign jalr_e        = ctrl_e.jalr;
    assign auipc_e       = ctrl_e.auipc;
    assign result_src_e  = ctrl_e.result_src;
    assign alu_control_e = ALUCTRL_W'(ctrl_e.alu);

`ifdef MULDIV_EN
    localparam int               CNT_W    = $clog2(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // a DIV/REM can only load while IDLE, since BUSY holds E
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_e) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == BUSY) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_nxt = IDLE;
            end
        end else if (valid_d && md_d && !stall_d) begin
            cnt_nxt   = LOAD_CNT;
            state_nxt = (LOAD_CNT != '0) ? BUSY : IDLE;
        end
    end

    assign md_stall = (state == BUSY);
`else
    localparam int unused_div_latency = DIV_LATENCY;
    assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed stimulus for pipe_controller; expected E-stage snapshots are queued and checked by a monitor.
module tb_pipe_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d, stall_d, flush_e;
    logic [2:0]  imm_src_d;
    logic        reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, auipc_e;
    logic [1:0]  result_src_e;
    logic [4:0]  alu_control_e;
    logic        valid_e, illegal_e, md_stall;

    always #5 clk = ~clk;

    pipe_controller #(.ALUCTRL_W(5), .IMMSRC_W(3), .DIV_LATENCY(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
        .stall_d(stall_d), .flush_e(flush_e), .imm_src_d(imm_src_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
        .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .auipc_e(auipc_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .valid_e(valid_e), .illegal_e(illegal_e), .md_stall(md_stall)
    );

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_LW    = 32'h00812283;
    localparam logic [31:0] I_SW    = 32'h00512423;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BLT   = 32'h0020C063;
    localparam logic [31:0] I_BBAD  = 32'h0020A063;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_SRAI  = 32'h40315093;
    localparam logic [31:0] I_SLTU  = 32'h003130B3;
    localparam logic [31:0] I_LUI   = 32'h123451B7;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] I_SUB   = 32'h403100B3;
    localparam logic [31:0] I_DIV   = 32'h023140B3;
`ifdef MULDIV_EN
    localparam logic [31:0] I_MUL   = 32'h023100B3;
`endif

    localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_MUL = 5'b00010, A_DIV = 5'b00011;
    localparam logic [4:0] A_SRA = 5'b00110, A_SLT = 5'b01011, A_SLTU = 5'b01100, A_PASSB = 5'b10000;

    typedef struct packed {
        logic       v, il, rw, mw, as, br, jp, jr, au;
        logic [1:0] rs;
        logic [4:0] alu;
        logic       ms;
        logic [2:0] imm;
    } obs_t;

    obs_t  sb[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic obs_t mk(input logic v, il, rw, mw, as, br, jp, jr, au,
                                input logic [1:0] rs, input logic [4:0] alu,
                                input logic ms, input logic [2:0] imm);
        obs_t o;
        o = {v, il, rw, mw, as, br, jp, jr, au, rs, alu, ms, imm};
        return o;
    endfunction

    function automatic obs_t rtype(input logic [4:0] alu, input logic ms);
        return mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, alu, ms, 3'b000);
    endfunction

    function automatic obs_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, A_ADD, 0, 3'b000);
    endfunction

    function automatic obs_t ill();
        return mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, A_ADD, 0, 3'b000);
    endfunction

    function obs_t sample();
        return {valid_e, illegal_e, reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e,
                jalr_e, auipc_e, result_src_e, alu_control_e, md_stall, imm_src_d};
    endfunction

    task automatic check(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (v il rw mw as br jp jr au rs alu ms imm)",
                     nm, got, want);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                        input obs_t want, input string nm);
        @(negedge clk);
        instr_d = ins;
        valid_d = v;
        stall_d = st;
        flush_e = fl;
        sb.push_back(want);
        nm_q.push_back(nm);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                obs_t  w;
                string n;
                w = sb.pop_front();
                n = nm_q.pop_front();
                check(n, sample(), w);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        instr_d = '0;
        valid_d = 1'b0;
        stall_d = 1'b0;
        flush_e = 1'b0;
        #12;
        check("reset_state", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        step(I_ADD,   1, 0, 0, rtype(A_ADD, 0), "add");
        step(I_LW,    1, 0, 0, mk(1,0,1,0,1,0,0,0,0,2'b01,A_ADD,0,3'b000), "lw");
        step(I_LW,    1, 1, 0, bub(), "stall_bubble");
        step(I_LW,    1, 0, 0, mk(1,0,1,0,1,0,0,0,0,2'b01,A_ADD,0,3'b000), "lw_after_stall");
        step(I_SW,    1, 0, 0, mk(1,0,0,1,1,0,0,0,0,2'b00,A_ADD,0,3'b001), "sw");
        step(I_BEQ,   1, 0, 0, mk(1,0,0,0,0,1,0,0,0,2'b00,A_SUB,0,3'b010), "beq");
        step(I_BLT,   1, 0, 0, mk(1,0,0,0,0,1,0,0,0,2'b00,A_SLT,0,3'b010), "blt");
        step(I_JAL,   1, 0, 0, mk(1,0,1,0,0,0,1,0,0,2'b10,A_ADD,0,3'b011), "jal");
        step(I_JALR,  1, 0, 0, mk(1,0,1,0,1,0,0,1,0,2'b10,A_ADD,0,3'b000), "jalr");
        step(I_AUIPC, 1, 0, 0, mk(1,0,1,0,1,0,0,0,1,2'b00,A_ADD,0,3'b100), "auipc");
        step(I_SRAI,  1, 0, 0, mk(1,0,1,0,1,0,0,0,0,2'b00,A_SRA,0,3'b000), "srai");
        step(I_SLTU,  1, 0, 0, rtype(A_SLTU, 0), "sltu");
        step(I_LUI,   1, 0, 0, mk(1,0,1,0,1,0,0,0,0,2'b00,A_PASSB,0,3'b100), "lui");
        step(I_ILL,   1, 0, 0, ill(), "all_ones_illegal");
        step(I_SUB,   1, 0, 0, rtype(A_SUB, 0), "sub");
        step(I_BBAD,  1, 0, 0, ill(), "branch_f3_illegal");
        step(I_ADD,   0, 0, 0, bub(), "valid_d_low");
        step(I_ADD,   1, 0, 1, bub(), "flush");
        step(I_ADD,   1, 0, 0, rtype(A_ADD, 0), "add_after_flush");

`ifdef MULDIV_EN
        step(I_DIV, 1, 0, 0, rtype(A_DIV, 1), "div_load");
        for (int i = 1; i <= 6; i++) step(I_ADD, 1, (i == 3), 0, rtype(A_DIV, 1), "div_hold");
        step(I_DIV, 1, 0, 0, rtype(A_DIV, 0), "div_last");
        step(I_DIV, 1, 0, 0, rtype(A_DIV, 1), "div_back_to_back");
        for (int i = 1; i <= 6; i++) step(I_ADD, 1, 0, 0, rtype(A_DIV, 1), "div2_hold");
        step(I_ADD, 1, 0, 0, rtype(A_DIV, 0), "div2_last");
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_after_div");
        step(I_MUL, 1, 0, 0, rtype(A_MUL, 0), "mul_single_cycle");
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_after_mul");
        step(I_DIV, 1, 0, 0, rtype(A_DIV, 1), "div_load_f");
        for (int i = 1; i <= 3; i++) step(I_ADD, 1, 0, 0, rtype(A_DIV, 1), "div_hold_f");
        step(I_ADD, 1, 0, 1, bub(), "flush_busy");
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_after_flush_busy");
        step(I_DIV, 1, 0, 0, rtype(A_DIV, 1), "div_load_r");
        step(I_ADD, 1, 0, 0, rtype(A_DIV, 1), "div_hold_r");
`else
        step(I_DIV, 1, 0, 0, ill(), "div_illegal_no_muldiv");
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_after_div");
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_before_reset");
`endif

        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        valid_d = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(I_ADD, 1, 0, 0, rtype(A_ADD, 0), "add_after_reset");

        @(negedge clk);
        valid_d = 1'b0;
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
Parametrised RV32 decode controller with a built-in D→E pipeline register. It decodes the D-stage instruction into control signals. ImmSrc is driven combinationally to the D-stage extend unit; all other controls are registered into the E stage under stall/flush control. A multi-cycle FSM holds a DIV/REM in E for DIV_LATENCY cycles and back-pressures the hazard unit. It adds jalr/lui/auipc, SRA/SLT/SLTU, explicit illegal-instruction flagging and correct REM encoding.

Parameters:
ALUCTRL_W, 5, ALU control width; must be ≥5; codes zero-extended.
IMMSRC_W, 3, immediate-select width; must be ≥3.
DIV_LATENCY, 8, total E-stage cycles occupied by DIV/DIVU/REM/REMU; must be ≥1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_d  in  32  D-stage instruction
valid_d  in  1  instr_d holds a real instruction
stall_d  in  1  hazard unit stall request (load-use)
flush_e  in  1  flush E (taken branch/jump)
imm_src_d  out  IMMSRC_W  combinational immediate select
reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e, auipc_e  out  1 each  registered controls
result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
alu_control_e  out  ALUCTRL_W  registered ALU op
valid_e  out  1  E holds a real instruction
illegal_e  out  1  E instruction is undecodable
md_stall  out  1  multi-cycle op busy; hazard unit must hold F/D

Behaviour:
- Reset (async, rst_n=0): all *_e outputs 0, md_stall 0, FSM IDLE, counter 0. Release is synchronous to clk.
- Decode by opcode: lw 0000011, sw 0100011, R 0110011, branch 1100011, I-ALU 0010011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
- imm_src_d: I=000 (lw/I-ALU/jalr), S=001, B=010, J=011, U=100. R-type and illegal give 000.
- ALU codes: ADD 00000, SUB 00001, MUL 00010, DIV 00011, SLL 00100, SRL 00101, SRA 00110, REM 00111, OR 01000, AND 01001, XOR 01010, SLT 01011, SLTU 01100, PASSB 10000.
- Mapping: lui→PASSB. auipc/lw/sw/jal/jalr→ADD. beq/bne→SUB. blt/bge→SLT. bltu/bgeu→SLTU.
- R-type with funct7=0100000 gives SUB (f3 000) or SRA (f3 101). I-ALU uses funct3 only, except srai, which requires funct7=0100000.
- Unsigned div/rem share the DIV/REM codes; the divider reads funct3 separately.
- Illegal: unknown opcode, or an undefined funct3/funct7 combination. All write enables are forced to 0 and illegal_e=1 in E. Outputs never carry X.
- E-register update priority, per edge:
  1. flush_e → bubble (all controls 0, valid_e 0, illegal_e 0); FSM forced IDLE, counter cleared.
  2. else md_stall → E holds.
  3. else stall_d → bubble.
  4. else load decode, with valid_e = valid_d. Controls are gated to 0 when valid_d=0.
- MD FSM, states IDLE/BUSY:
  - A valid DIV/REM loaded into E sets counter to DIV_LATENCY-1. State goes BUSY if that value is >0, otherwise stays IDLE.
  - In BUSY the counter decrements every cycle; the FSM returns to IDLE on the edge where counter==1.
  - md_stall = (state==BUSY), registered. The DIV/REM occupies E exactly DIV_LATENCY cycles with md_stall high DIV_LATENCY-1 cycles.
  - MUL is single-cycle and never enters BUSY.
  - Back-to-back DIVs: the second loads on the cycle md_stall drops and restarts the count.
  - stall_d while BUSY is ignored, since the hold takes priority.

Optional Feature:
MULDIV_EN.
- Defined: funct7=0000001 R-type decodes MUL (f3 000), DIV/DIVU (f3 100/101), REM/REMU (f3 110/111); FSM and counter are present.
- Undefined: all funct7=0000001 encodings are illegal, md_stall is tied 0, and no FSM or counter logic is synthesised.

Test Plan:
1. Reset, then add x1,x2,x3 (0x003100B3) with valid_d=1 → next edge: reg_write_e=1, alu_src_e=0, result_src_e=00, alu_control_e=00000, valid_e=1, illegal_e=0.
2. lw x5,8(x2) (0x00812283) → imm_src_d=000 combinationally; next edge: alu_src_e=1, result_src_e=01, mem_write_e=0, reg_write_e=1. Then stall_d=1 for one cycle → bubble: valid_e=0, reg_write_e=0.
3. MULDIV_EN, DIV_LATENCY=8: div x1,x2,x3 (0x023140B3) → alu_control_e=00011 held 8 cycles, md_stall high exactly 7 cycles. A following add loads on the cycle md_stall falls.
4. div in BUSY with counter=4, assert flush_e → next edge: all E controls 0, md_stall 0, FSM IDLE. Also: rst_n pulsed low mid-div → outputs 0 immediately, without a clock edge.
5. 0xFFFFFFFF, then sub x1,x2,x3 (0x403100B3) → first: illegal_e=1, reg_write_e=0, mem_write_e=0. Second: alu_control_e=00001, illegal_e=0.
6. Build without MULDIV_EN, issue 0x023140B3 → illegal_e=1, md_stall stays 0. Also: lui x3,0x12345 (0x123451B7) → imm_src_d=100, alu_control_e=10000, alu_src_e=1, reg_write_e=1.
